jk_count_sequencer: RTL and testbench

// - Controller that sequences a WIDTH-bit bank of JK storage cells as a programmable up/down counter.
// - Per bit and per cycle it drives J/K as HOLD, SET, RESET or TOGGLE.
// - Offers a start/done handshake to a host FSM: load a start value, count toward a terminal value, report completion.
// - Sits between lab-board control logic and the flip-flop primitives; the only writer of the JK bank.

---
 rtl/jk_count_sequencer_pkg.sv | 5 +
 rtl/jk_count_sequencer_jk_bit.sv | 17 +
 rtl/jk_count_sequencer.sv | 83 ++++++++
 tb/tb_jk_count_sequencer.sv | 99 +++++++++
 4 files changed

// File: rtl/jk_count_sequencer_pkg.sv
// jk_count_sequencer_pkg: shared state encodings and JK op codes for the counter sequencer
package jk_count_sequencer_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, DONE = 2'b11} state_t;
  typedef enum logic [1:0] {HOLD = 2'b00, RESET = 2'b01, SET = 2'b10, TOGGLE = 2'b11} jk_op_t;
endpackage

// File: rtl/jk_count_sequencer_jk_bit.sv
// jk_bit: single JK storage cell, async active-low clear
// Ports: clk, rst (active-low async), j/k drive inputs, q stored bit.
module jk_bit
  import jk_count_sequencer_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q
);
  jk_op_t op;
  assign op = jk_op_t'({j, k});
  always_ff @(posedge clk or negedge rst)
    if (!rst) q <= 1'b0;
    else q <= op == SET ? 1'b1 : op == RESET ? 1'b0 : op == TOGGLE ? ~q : q;
endmodule

// File: rtl/jk_count_sequencer.sv
// jk_count_sequencer: drives a WIDTH-bit JK bank as a loadable up/down counter with start/done handshake
// Ports: clk; rst (async, active-low); start/load_val/term_val/up_dn capture a run; en gates
// counting; abort cancels; done_ack releases DONE; q bank contents; j/k the vectors applied at
// the last edge; busy in RUN/DONE; done in DONE.
module jk_count_sequencer
  import jk_count_sequencer_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] term_val,
  input  logic             up_dn,
  input  logic             en,
  input  logic             abort,
  input  logic             done_ack,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             busy,
  output logic             done
);
  state_t state, st_n;
  logic [WIDTH-1:0] cap_term, tmask, q_step, j_n, k_n;
  logic cap_up;
  // Ripple carry/borrow chain: bit i toggles when every lower bit is 1 (up) or 0 (down).
  always_comb begin
    logic c;
    c = 1'b1;
    tmask = '0;
    for (int i = 0; i < WIDTH; i++) begin
      tmask[i] = c;
      c = c & (cap_up ? q[i] : ~q[i]);
    end
  end
  assign q_step = q ^ tmask;
  // The bank is clocked by the same vectors that are registered onto j/k, so q and j/k agree.
  always_comb begin
    j_n = '0;
    k_n = '0;
    st_n = state;
    case (state)
      IDLE: if (start) begin
        j_n = load_val;
        k_n = ~load_val;
        st_n = load_val == term_val ? DONE : RUN;
      end
      RUN: if (abort) st_n = IDLE;
        else if (en) begin
          j_n = tmask;
          k_n = tmask;
          st_n = q_step == cap_term ? DONE : RUN;
        end
      DONE: if (done_ack || abort) st_n = IDLE;
      default: st_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      cap_term <= '0;
      cap_up <= 1'b0;
      j <= '0;
      k <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= st_n;
      j <= j_n;
      k <= k_n;
      busy <= st_n != IDLE;
      done <= st_n == DONE;
      if (state == IDLE && start) begin
        cap_term <= term_val;
        cap_up <= up_dn;
      end
    end
  for (genvar g = 0; g < WIDTH; g++) begin : g_bank
    jk_bit u_bit (.clk(clk), .rst(rst), .j(j_n[g]), .k(k_n[g]), .q(q[g]));
  end
endmodule

// File: tb/tb_jk_count_sequencer.sv
// tb_jk_count_sequencer: directed and random checks of jk_count_sequencer against an integer counter model
module tb_jk_count_sequencer;
  localparam int W = 4;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0, up_dn = 1'b0, en = 1'b0, abort = 1'b0, done_ack = 1'b0;
  logic [W-1:0] load_val = '0, term_val = '0, q, j, k;
  logic busy, done;
  int n_chk = 0, n_err = 0;
  logic [W-1:0] m_q = '0, m_term = '0, m_j = '0, m_k = '0;
  logic m_up = 1'b0;
  int m_st = 0;
  always #5 clk = ~clk;
  jk_count_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .load_val(load_val), .term_val(term_val),
    .up_dn(up_dn), .en(en), .abort(abort), .done_ack(done_ack),
    .q(q), .j(j), .k(k), .busy(busy), .done(done)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic chk_all(input string tag);
    chk({tag, ".q"}, 32'(q), 32'(m_q));
    chk({tag, ".j"}, 32'(j), 32'(m_j));
    chk({tag, ".k"}, 32'(k), 32'(m_k));
    chk({tag, ".busy"}, 32'(busy), 32'(m_st != 0));
    chk({tag, ".done"}, 32'(done), 32'(m_st == 2));
  endtask
  task automatic model_reset();
    m_q = '0; m_term = '0; m_j = '0; m_k = '0; m_up = 1'b0; m_st = 0;
  endtask
  // m_st: 0 idle, 1 counting, 2 finished; j/k model is the set of bits that changed
  task automatic step(input string tag, input logic s, input logic [W-1:0] lv, input logic [W-1:0] tv,
                      input logic ud, input logic e, input logic ab, input logic ack);
    logic [W-1:0] nq;
    @(negedge clk);
    start = s; load_val = lv; term_val = tv; up_dn = ud; en = e; abort = ab; done_ack = ack;
    @(posedge clk);
    m_j = '0;
    m_k = '0;
    if (m_st == 0) begin
      if (s) begin
        m_q = lv; m_j = lv; m_k = ~lv; m_term = tv; m_up = ud;
        m_st = lv == tv ? 2 : 1;
      end
    end else if (m_st == 1) begin
      if (ab) m_st = 0;
      else if (e) begin
        nq = m_up ? m_q + 1'b1 : m_q - 1'b1;
        m_j = m_q ^ nq;
        m_k = m_j;
        m_q = nq;
        if (nq == m_term) m_st = 2;
      end
    end else if (ab || ack) m_st = 0;
    #1 chk_all(tag);
  endtask
  initial begin
    #2 chk_all("por");
    @(negedge clk) rst = 1'b1;
    step("up_start", 1, 3, 7, 1, 1, 0, 0);
    repeat (4) step("up_run", 0, 0, 0, 0, 1, 0, 0);
    step("up_ack", 0, 0, 0, 0, 0, 0, 1);
    step("dn_start", 1, 1, 14, 0, 1, 0, 0);
    repeat (3) step("dn_run", 0, 0, 0, 1, 1, 0, 0);
    step("dn_ack", 0, 0, 0, 0, 0, 0, 1);
    step("gap_start", 1, 0, 3, 1, 0, 0, 0);
    step("gap_e1", 0, 0, 0, 0, 1, 0, 0);
    step("gap_e0", 0, 0, 0, 0, 0, 0, 0);
    step("gap_e0", 0, 0, 0, 0, 0, 0, 0);
    step("gap_e1", 0, 0, 0, 0, 1, 0, 0);
    step("gap_e1", 0, 0, 0, 0, 1, 0, 0);
    step("gap_ack", 0, 0, 0, 0, 0, 0, 1);
    step("eq_start", 1, 5, 5, 1, 1, 0, 0);
    step("eq_hold", 0, 0, 0, 0, 1, 0, 0);
    step("eq_ack", 1, 9, 2, 1, 1, 0, 1);
    step("eq_idle", 0, 0, 0, 0, 1, 0, 0);
    step("ign_start", 1, 2, 10, 1, 1, 0, 0);
    repeat (3) step("ign_pulse", 1, 13, 4, 0, 1, 0, 0);
    step("ign_abort", 0, 0, 0, 0, 1, 1, 0);
    step("ab_start", 1, 0, 12, 1, 1, 0, 0);
    repeat (9) step("ab_run", 0, 0, 0, 0, 1, 0, 0);
    step("ab_abort", 0, 0, 0, 0, 1, 1, 0);
    step("ab_idle", 0, 0, 0, 0, 1, 0, 0);
    step("rst_start", 1, 6, 2, 1, 1, 0, 0);
    repeat (3) step("rst_run", 0, 0, 0, 0, 1, 0, 0);
    #2 rst = 1'b0;
    #1 model_reset();
    chk_all("async_rst");
    @(negedge clk) rst = 1'b1;
    for (int n = 0; n < 800; n++)
      step("rand", $urandom_range(0, 3) == 0, W'($urandom), W'($urandom), 1'($urandom),
           $urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0, $urandom_range(0, 2) == 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule
